// File: rtl/ncc_sequencer_pkg.sv
// Shared constants and state type for the NCC PE-array control sequencer.
// Widths are derived from the array and window geometry.
package ncc_pkg;

  localparam int PE_ROWS      = 16;
  localparam int PE_COLS      = 16;
  localparam int WIN_WIDTH    = 640;
  localparam int WIN_ROWS     = 16;
  localparam int PIX_PER_WORD = 4;
  localparam int DESC_WORDS   = PE_ROWS * PE_COLS / PIX_PER_WORD;

  localparam int COL_W  = $clog2(WIN_WIDTH);
  localparam int ROW_W  = $clog2(WIN_ROWS);
  localparam int DCNT_W = $clog2(DESC_WORDS);
  localparam int DROW_W = $clog2(PE_ROWS);
  localparam int CGRP_W = $clog2(PE_COLS / PIX_PER_WORD);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DESC,
    S_WIN,
    S_DRAIN,
    S_DONE
  } ncc_seq_state_t;

endpackage

// File: rtl/ncc_sequencer_if.sv
// Descriptor, window-pixel and result handshakes between DMA, sequencer and PE array.
// The slave modport is the sequencer side; master is the DMA/consumer side.
interface ncc_sequencer_if;
  import ncc_pkg::*;

  logic              desc_valid;
  logic              desc_ready;
  logic              desc_load;
  logic [DROW_W-1:0] desc_row;
  logic [CGRP_W-1:0] desc_colgrp;

  logic              win_valid;
  logic              win_ready;
  logic              win_load;
  logic              acc_load;

  logic              res_valid;
  logic              res_ready;
  logic [COL_W-1:0]  res_col;
  logic [ROW_W-1:0]  res_row;

  modport master (
    output desc_valid, win_valid, res_ready,
    input  desc_ready, desc_load, desc_row, desc_colgrp,
    input  win_ready, win_load, acc_load,
    input  res_valid, res_col, res_row
  );

  modport slave (
    input  desc_valid, win_valid, res_ready,
    output desc_ready, desc_load, desc_row, desc_colgrp,
    output win_ready, win_load, acc_load,
    output res_valid, res_col, res_row
  );

endinterface

// File: rtl/ncc_sequencer_counters.sv
// Plain free-running counter (descriptor words) and a terminal-count wrap counter
// (window column/row) with synchronous clear.
module counter #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

module wrap_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] term,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  // wrap flags the enabled step that returns the count to zero
  assign wrap = en && (count == term);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/ncc_sequencer.sv
// Sequencer for one NCC match: loads 64 descriptor words into the PE array, then
// streams the window pixels and emits one result strobe per valid column position.
module ncc_sequencer
  import ncc_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  ncc_sequencer_if.slave     bus,
  output logic               busy,
  output logic               done
);

  localparam logic [DCNT_W-1:0] DESC_LAST = DCNT_W'(DESC_WORDS - 1);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(WIN_WIDTH - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(WIN_ROWS - 1);
  localparam logic [COL_W-1:0]  COL_FIRST_RES = COL_W'(PE_COLS - 1);

  ncc_seq_state_t    state_reg, state_next;
  logic [DCNT_W-1:0] dcnt;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic              col_wrap, row_wrap;
  logic              cnt_clr;
  logic              desc_rdy, win_rdy, done_int;
  logic              desc_hs, win_hs, res_set;
  logic              res_valid_reg;
  logic [COL_W-1:0]  res_col_reg;
  logic [ROW_W-1:0]  res_row_reg;

  assign desc_hs = bus.desc_valid & desc_rdy;
  assign win_hs  = bus.win_valid & win_rdy;
  // Columns below PE_COLS-1 only fill the array pipeline
  assign res_set = win_hs && (col >= COL_FIRST_RES);

  counter #(.WIDTH(DCNT_W)) u_dcnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (desc_hs),
    .count (dcnt)
  );

  wrap_counter #(.WIDTH(COL_W)) u_col (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (win_hs),
    .term  (COL_LAST),
    .count (col),
    .wrap  (col_wrap)
  );

  wrap_counter #(.WIDTH(ROW_W)) u_row (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (col_wrap),
    .term  (ROW_LAST),
    .count (row),
    .wrap  (row_wrap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_clr    = 1'b0;
    desc_rdy   = 1'b0;
    win_rdy    = 1'b0;
    done_int   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          cnt_clr    = 1'b1;
          state_next = S_DESC;
        end
      end
      S_DESC: begin
        desc_rdy = 1'b1;
        if (bus.desc_valid && (dcnt == DESC_LAST)) begin
          state_next = S_WIN;
        end
      end
      S_WIN: begin
        // A held result stalls the stream so it can never be overwritten
        win_rdy = !(res_valid_reg && !bus.res_ready);
        if (bus.win_valid && win_rdy && row_wrap) begin
          state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!res_valid_reg || bus.res_ready) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        done_int   = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_reg <= 1'b0;
      res_col_reg   <= '0;
      res_row_reg   <= '0;
    end else if (res_set) begin
      res_valid_reg <= 1'b1;
      res_col_reg   <= col;
      res_row_reg   <= row;
    end else if (bus.res_ready) begin
      res_valid_reg <= 1'b0;
    end
  end

  assign bus.desc_ready  = desc_rdy;
  assign bus.desc_load   = desc_hs;
  assign bus.desc_row    = dcnt[DCNT_W-1:CGRP_W];
  assign bus.desc_colgrp = dcnt[CGRP_W-1:0];
  assign bus.win_ready   = win_rdy;
  assign bus.win_load    = win_hs;
  assign bus.acc_load    = win_hs;
  assign bus.res_valid   = res_valid_reg;
  assign bus.res_col     = res_col_reg;
  assign bus.res_row     = res_row_reg;
  assign busy            = (state_reg != S_IDLE);
  assign done            = done_int;

endmodule

// File: tb/tb_ncc_sequencer.sv
// Self-checking bench for ncc_sequencer: descriptor vector table, hand-written
// corner sequences, and a randomized window stream checked against a result queue model.
module tb_ncc_sequencer;
  import ncc_pkg::*;

  typedef struct {
    logic valid;
    logic load;
    int   row;
    int   grp;
  } dvec_t;

  typedef struct {
    int col;
    int row;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, done;

  ncc_sequencer_if bus();

  ncc_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bus   (bus.slave),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  res_t exp_q[$];
  int   pix_cnt = 0;
  int   res_cnt = 0;
  int   last_col = -1;
  int   last_row = -1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_desc_ready"}, int'(bus.desc_ready), 0);
    check({tag, "_desc_load"}, int'(bus.desc_load), 0);
    check({tag, "_win_ready"}, int'(bus.win_ready), 0);
    check({tag, "_win_load"}, int'(bus.win_load), 0);
    check({tag, "_acc_load"}, int'(bus.acc_load), 0);
    check({tag, "_res_valid"}, int'(bus.res_valid), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_res_col"}, int'(bus.res_col), 0);
    check({tag, "_res_row"}, int'(bus.res_row), 0);
    check({tag, "_desc_row"}, int'(bus.desc_row), 0);
    check({tag, "_desc_colgrp"}, int'(bus.desc_colgrp), 0);
  endtask

  // Reference model: every accepted pixel is numbered in raster order; pixels at
  // column >= PE_COLS-1 each owe exactly one result, delivered in order.
  always @(negedge clk) begin
    if (!rst_n) begin
      pix_cnt = 0;
      res_cnt = 0;
      exp_q.delete();
    end else begin
      if (start && !busy) begin
        pix_cnt = 0;
        res_cnt = 0;
        exp_q.delete();
      end
      check("win_load_vs_handshake", int'(bus.win_load), int'(bus.win_valid && bus.win_ready));
      check("acc_load_vs_handshake", int'(bus.acc_load), int'(bus.win_valid && bus.win_ready));
      if (bus.res_valid && !bus.res_ready) begin
        check("win_ready_stall", int'(bus.win_ready), 0);
      end
      if (bus.win_valid && bus.win_ready) begin
        if ((pix_cnt % WIN_WIDTH) >= PE_COLS - 1) begin
          exp_q.push_back('{pix_cnt % WIN_WIDTH, pix_cnt / WIN_WIDTH});
        end
        pix_cnt++;
      end
      if (bus.res_valid && bus.res_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result actual=col %0d row %0d required=no result",
                   bus.res_col, bus.res_row);
        end else begin
          res_t e;
          e = exp_q.pop_front();
          check("res_col", int'(bus.res_col), e.col);
          check("res_row", int'(bus.res_row), e.row);
        end
        res_cnt++;
        last_col = int'(bus.res_col);
        last_row = int'(bus.res_row);
      end
    end
  end

  initial begin
    dvec_t dtab[70];
    int    w;
    int    dones;
    int    n;
    logic  v;

    // 70 descriptor cycles with 6 bubbles -> exactly 64 accepted words
    w = 0;
    for (int i = 0; i < 70; i++) begin
      v = !(i == 3 || i == 20 || i == 41 || i == 50 || i == 60 || i == 66);
      dtab[i] = '{v, v, w / 4, w % 4};
      if (v) w++;
    end

    bus.desc_valid = 1'b0;
    bus.win_valid  = 1'b0;
    bus.res_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_cleared("reset");
    rst_n = 1'b1;
    tick();

    // Reset in the middle of descriptor load
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_desc_ready", int'(bus.desc_ready), 1);
    check("start_busy", int'(busy), 1);
    bus.desc_valid = 1'b1;
    repeat (10) tick();
    check("word10_row", int'(bus.desc_row), 2);
    check("word10_grp", int'(bus.desc_colgrp), 2);
    #2;
    rst_n = 1'b0;
    #1;
    check_cleared("mid_desc_reset");
    bus.desc_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Descriptor table
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 70; i++) begin
      bus.desc_valid = dtab[i].valid;
      #1;
      check($sformatf("desc_load[%0d]", i), int'(bus.desc_load), int'(dtab[i].load));
      check($sformatf("desc_row[%0d]", i), int'(bus.desc_row), dtab[i].row);
      check($sformatf("desc_colgrp[%0d]", i), int'(bus.desc_colgrp), dtab[i].grp);
      tick();
    end
    bus.desc_valid = 1'b0;
    check("after_desc_win_ready", int'(bus.win_ready), 1);
    check("after_desc_desc_ready", int'(bus.desc_ready), 0);

    // Pipeline fill: first 16 pixels
    bus.res_ready = 1'b1;
    bus.win_valid = 1'b1;
    for (int p = 0; p < 16; p++) begin
      #1;
      check($sformatf("fill_res_valid[%0d]", p), int'(bus.res_valid), 0);
      check($sformatf("fill_win_load[%0d]", p), int'(bus.win_load), 1);
      tick();
    end
    check("first_res_valid", int'(bus.res_valid), 1);
    check("first_res_col", int'(bus.res_col), 15);
    check("first_res_row", int'(bus.res_row), 0);

    // Backpressure for 5 cycles
    bus.res_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      check($sformatf("stall_win_ready[%0d]", c), int'(bus.win_ready), 0);
      check($sformatf("stall_win_load[%0d]", c), int'(bus.win_load), 0);
      check($sformatf("stall_res_valid[%0d]", c), int'(bus.res_valid), 1);
      check($sformatf("stall_res_col[%0d]", c), int'(bus.res_col), 15);
      tick();
    end
    bus.res_ready = 1'b1;
    #1;
    check("resume_win_ready", int'(bus.win_ready), 1);
    check("resume_win_load", int'(bus.win_load), 1);
    tick();

    // Randomized rest of the match, with stray start/desc_valid during WIN
    dones = 0;
    for (n = 0; n < 60000; n++) begin
      bus.win_valid  = ($urandom_range(0, 3) != 0);
      bus.res_ready  = ($urandom_range(0, 3) != 0);
      bus.desc_valid = ($urandom_range(0, 1) != 0);
      start = (pix_cnt < 10000) ? ($urandom_range(0, 15) == 0) : 1'b0;
      #1;
      if (bus.desc_valid) check("stray_desc_load", int'(bus.desc_load), 0);
      check("stray_busy", int'(busy), 1);
      if (done) begin
        dones++;
        break;
      end
      tick();
    end
    check("rand_done_seen", dones, 1);
    start = 1'b0;
    bus.desc_valid = 1'b0;
    bus.win_valid = 1'b0;
    tick();
    check("rand_after_done_busy", int'(busy), 0);
    check("rand_after_done_done", int'(done), 0);
    check("rand_pixels", pix_cnt, WIN_WIDTH * WIN_ROWS);
    check("rand_results", res_cnt, (WIN_WIDTH - PE_COLS + 1) * WIN_ROWS);
    check("rand_queue_empty", exp_q.size(), 0);

    // Full run at full throughput
    start = 1'b1;
    tick();
    start = 1'b0;
    bus.desc_valid = 1'b1;
    repeat (DESC_WORDS) tick();
    bus.desc_valid = 1'b0;
    bus.win_valid = 1'b1;
    bus.res_ready = 1'b1;
    dones = 0;
    for (n = 0; n < 20000; n++) begin
      #1;
      if (done) dones++;
      if (!busy) break;
      tick();
    end
    bus.win_valid = 1'b0;
    check("full_done_pulses", dones, 1);
    check("full_busy_end", int'(busy), 0);
    check("full_results", res_cnt, 10000);
    check("full_last_col", last_col, 639);
    check("full_last_row", last_row, 15);
    check("full_queue_empty", exp_q.size(), 0);
    check("full_cycles", int'(n < 20000), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ncc_sequencer.md
# ncc_sequencer

Control sequencer for the 16x16 NCC processing-element array. It handles the two phases of one match: descriptor load and window stream.
- Descriptor load: accepts 64 packed descriptor words (4 × 8-bit pixels each) over a valid/ready handshake. For each word it drives the row/column-group load strobes.
- Window stream: streams window pixels into the array, pulsing the window-register and accumulator loads. It emits one correlation-result strobe per valid window column position, with backpressure.

It sits between the frame/descriptor DMA and the PE array.

## Interface
- PE_ROWS, 16, PE array rows (descriptor rows)
- PE_COLS, 16, PE array columns; 4 pixels per word gives PE_COLS/4 = 4 column groups
- WIN_WIDTH, 640, window pixels per row
- WIN_ROWS, 16, window rows per match
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; ignored unless in IDLE
- desc_valid  in  1  descriptor word valid
- desc_ready  out  1  descriptor word accepted when valid&ready
- desc_load  out  1  array descriptor-register load strobe
- desc_row  out  4  target PE row for desc_load
- desc_colgrp  out  2  target column group for desc_load
- win_valid  in  1  window pixel valid
- win_ready  out  1  window pixel accepted when valid&ready
- win_load  out  1  array window-register load strobe
- acc_load  out  1  array accumulator-register load strobe
- res_valid  out  1  array accOut row holds a valid result
- res_ready  in  1  result consumer accepts
- res_col  out  10  window column index of current result
- res_row  out  4  window row index of current result
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at end of match

## Operation
- States: IDLE, DESC, WIN, DRAIN, DONE.
- **IDLE**
  - All strobes low.
  - start → DESC; clear all counters.
- **DESC**
  - desc_ready=1.
  - Handshake behaviour:
    - desc_load = desc_valid & desc_ready, combinational in the same cycle.
    - desc_row = dcnt[5:2]; desc_colgrp = dcnt[1:0], where dcnt is a 6-bit word counter (row-major, column group fastest).
  - dcnt increments on each handshake.
  - Handshake at dcnt=63 → WIN.
  - start is ignored while not in IDLE.
- **WIN**
  - win_ready = !(res_valid & !res_ready).
  - On a window handshake:
    - win_load and acc_load are asserted that cycle.
    - Column counter col (0..WIN_WIDTH-1) increments; it wraps to 0 and increments row (0..WIN_ROWS-1).
  - Result generation:
    - A handshake with col ≥ PE_COLS-1 sets res_valid the next cycle, with res_col=col and res_row=row captured.
    - Columns 0..PE_COLS-2 are pipeline fill and produce no result.
  - res_valid clears on res_ready unless a new result is set in the same cycle; a new result takes priority and reloads res_col/res_row.
  - Handshake at col=WIN_WIDTH-1, row=WIN_ROWS-1 → DRAIN.
- **DRAIN**
  - win_ready=0.
  - Waits until res_valid=0, or res_valid & res_ready → DONE.
- **DONE**
  - done=1 for one cycle → IDLE.
- Counter rules:
  - Counters are unsigned and never exceed their bounds.
  - Column counter is $clog2(WIN_WIDTH) bits.
  - Row counter is $clog2(WIN_ROWS) bits.
- Reset (any time, including mid-phase):
  - State → IDLE, all counters → 0.
  - desc_ready, desc_load, win_ready, win_load, acc_load, res_valid, busy, done → 0.
  - res_col, res_row, desc_row, desc_colgrp → 0.

## Timing
- desc_load, win_load and acc_load are combinational from the handshake, so the array registers capture on the same edge that the word or pixel is accepted.
- Result latency: res_valid rises 1 cycle after the accepted pixel (matches the accumulator register).
- Throughput: 1 descriptor word per cycle, and 1 window pixel per cycle when res_ready stays high.
- Backpressure: a held result (res_valid & !res_ready) stalls win_ready in the same cycle, so no result is ever overwritten.
- start → desc_ready high: 1 cycle.
- Final handshake → done pulse:
  - ≥2 cycles: WIN → DRAIN, DRAIN → DONE.
  - Longer if res_ready is held low.

## Structure
- Shared package `ncc_pkg`:
  - State enum `ncc_seq_state_t`.
  - Constants PIX_PER_WORD=4 and DESC_WORDS=PE_ROWS*PE_COLS/PIX_PER_WORD=64.
- Sub-module: reuse the existing `counter` for dcnt. Write a local `wrap_counter` (enable, terminal count, wrap flag) for col/row.
- The FSM with one state register and a combinational next-state/output block lives in `ncc_sequencer`.

## Test plan
1. Reset mid-DESC after 10 words → all outputs 0, state IDLE; after start, the next word loads with desc_row=0, desc_colgrp=0.
2. start, then 64 back-to-back words → desc_load high 64 cycles; word 5 gives row 1, colgrp 1; word 63 gives row 15, colgrp 3; win_ready high the next cycle.
3. Stream the first 16 pixels of row 0 → no res_valid for pixels 0–14; res_valid rises the cycle after pixel 15 with res_col=15, res_row=0.
4. res_ready held low for 5 cycles mid-row → win_ready low for those cycles; no win_load; res_col unchanged; streaming resumes the cycle res_ready returns.
5. Full run of 640×16 pixels, res_ready=1 → exactly 625×16=10000 results; last result res_col=639, res_row=15; done pulses once, then busy=0.
6. start asserted during WIN, and desc_valid asserted during WIN → both ignored; counters unaffected.
